// File: rtl/processing_element_pipe.sv
// processing_element_pipe
// Two-stage vector-lane processing element with valid/ready handshakes.
// Stage 1 captures the beat and its full-width signed product; stage 2
// evaluates ADD / fixed-point MUL / MAC / RELU6, narrows the result and
// loads the output register. A single enable stalls both stages together.
module processing_element_pipe #(
  parameter int W_DATA = 8,
  parameter int W_ACC  = 12,
  parameter int FRAC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_DATA-1:0] in_a,
  input  logic [W_DATA-1:0] in_b,
  input  logic [W_DATA-1:0] in_c,
  input  logic              in_last,
  input  logic [1:0]        cfg_op,
  input  logic              cfg_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_DATA-1:0] out_r,
  output logic [W_ACC-1:0]  out_acc,
  output logic              out_sat
);

  // Product width and a working width wide enough that no intermediate sum
  // (accumulator + saturated product, or the raw shifted product) can wrap.
  localparam int W_P = 2 * W_DATA;
  localparam int W_X = ((W_P > (W_ACC + 1)) ? W_P : (W_ACC + 1)) + 1;

  localparam logic signed [W_X-1:0] ACC_MAX_X  =
    signed'({{(W_X - W_ACC + 1){1'b0}}, {(W_ACC - 1){1'b1}}});
  localparam logic signed [W_X-1:0] ACC_MIN_X  =
    signed'({{(W_X - W_ACC + 1){1'b1}}, {(W_ACC - 1){1'b0}}});
  localparam logic signed [W_X-1:0] DATA_MAX_X =
    signed'({{(W_X - W_DATA + 1){1'b0}}, {(W_DATA - 1){1'b1}}});
  localparam logic signed [W_X-1:0] DATA_MIN_X =
    signed'({{(W_X - W_DATA + 1){1'b1}}, {(W_DATA - 1){1'b0}}});
  localparam logic signed [W_X-1:0] RELU_MAX_X =
    signed'({{(W_X - 3){1'b0}}, 3'd6}) <<< FRAC;

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_MUL   = 2'd1,
    OP_MAC   = 2'd2,
    OP_RELU6 = 2'd3
  } op_e;

  // ---------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------
  function automatic logic signed [W_X-1:0] sext_data(input logic [W_DATA-1:0] v);
    return {{(W_X - W_DATA){v[W_DATA-1]}}, v};
  endfunction

  function automatic logic signed [W_X-1:0] sext_acc(input logic [W_ACC-1:0] v);
    return {{(W_X - W_ACC){v[W_ACC-1]}}, v};
  endfunction

  function automatic logic [W_ACC-1:0] sat_acc(input logic signed [W_X-1:0] v);
    logic [W_ACC-1:0] r;
    if (v > ACC_MAX_X) begin
      r = ACC_MAX_X[W_ACC-1:0];
    end else if (v < ACC_MIN_X) begin
      r = ACC_MIN_X[W_ACC-1:0];
    end else begin
      r = v[W_ACC-1:0];
    end
    return r;
  endfunction

  function automatic logic ovf_acc(input logic signed [W_X-1:0] v);
    return (v > ACC_MAX_X) || (v < ACC_MIN_X);
  endfunction

  function automatic logic [W_DATA-1:0] sat_data(input logic signed [W_X-1:0] v);
    logic [W_DATA-1:0] r;
    if (v > DATA_MAX_X) begin
      r = DATA_MAX_X[W_DATA-1:0];
    end else if (v < DATA_MIN_X) begin
      r = DATA_MIN_X[W_DATA-1:0];
    end else begin
      r = v[W_DATA-1:0];
    end
    return r;
  endfunction

  function automatic logic ovf_data(input logic signed [W_X-1:0] v);
    return (v > DATA_MAX_X) || (v < DATA_MIN_X);
  endfunction

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  logic en_s;
  logic accept_s;

  logic                    s1_valid_q, s1_valid_d;
  logic [W_DATA-1:0]       s1_a_q,     s1_a_d;
  logic [W_DATA-1:0]       s1_b_q,     s1_b_d;
  logic [W_DATA-1:0]       s1_c_q,     s1_c_d;
  op_e                     s1_op_q,    s1_op_d;
  logic                    s1_sat_q,   s1_sat_d;
  logic                    s1_last_q,  s1_last_d;
  logic signed [W_P-1:0]   s1_prod_q,  s1_prod_d;

  logic [W_ACC-1:0]        acc_q,        acc_d;
  logic                    mac_active_q, mac_active_d;
  logic                    mac_sat_q,    mac_sat_d;

  logic                    out_valid_q, out_valid_d;
  logic [W_DATA-1:0]       out_r_q,     out_r_d;
  logic [W_ACC-1:0]        out_acc_q,   out_acc_d;
  logic                    out_sat_q,   out_sat_d;

  logic signed [W_P-1:0]   prod_a_s, prod_b_s;
  logic signed [W_P-1:0]   prod_sh_s;
  logic signed [W_X-1:0]   a_x_s, b_x_s, c_x_s, p_x_s, sum_x_s, mac_x_s, narrow_x_s;
  logic [W_ACC-1:0]        p_acc_s, base_acc_s, mac_acc_s;
  logic                    p_ovf_s, mac_ovf_s, mac_wsat_s;
  logic [W_ACC-1:0]        res_acc_s;
  logic                    res_wsat_s, res_nsat_s;
  logic [W_DATA-1:0]       res_r_s;
  logic                    emit_s, mac_step_s;

  // The whole pipeline advances only when the output slot is free or draining.
  assign en_s      = !out_valid_q || out_ready;
  assign in_ready  = en_s && !rst;
  assign accept_s  = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_acc   = out_acc_q;
  assign out_sat   = out_sat_q;

  // ---------------------------------------------------------------------
  // Stage 1: capture the beat and form the full-width signed product
  // ---------------------------------------------------------------------
  // Stage-1 next state: load on enable, valid reflects acceptance.
  always_comb begin
    prod_a_s   = {{(W_P - W_DATA){in_a[W_DATA-1]}}, in_a};
    prod_b_s   = {{(W_P - W_DATA){in_b[W_DATA-1]}}, in_b};
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    s1_op_d    = s1_op_q;
    s1_sat_d   = s1_sat_q;
    s1_last_d  = s1_last_q;
    s1_prod_d  = s1_prod_q;
    if (en_s) begin
      s1_valid_d = accept_s;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_c_d     = in_c;
      s1_op_d    = op_e'(cfg_op);
      s1_sat_d   = cfg_sat;
      s1_last_d  = in_last;
      s1_prod_d  = prod_a_s * prod_b_s;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: evaluate the operation, saturate, narrow
  // ---------------------------------------------------------------------
  // Stage-2 datapath: per-op wide result, saturation flags and narrowing.
  always_comb begin
    a_x_s      = sext_data(s1_a_q);
    b_x_s      = sext_data(s1_b_q);
    c_x_s      = sext_data(s1_c_q);
    prod_sh_s  = s1_prod_q >>> FRAC;
    p_x_s      = {{(W_X - W_P){prod_sh_s[W_P-1]}}, prod_sh_s};
    sum_x_s    = a_x_s + b_x_s;
    p_acc_s    = sat_acc(p_x_s);
    p_ovf_s    = ovf_acc(p_x_s);
    if (mac_active_q) begin
      base_acc_s = acc_q;
    end else begin
      base_acc_s = c_x_s[W_ACC-1:0];
    end
    mac_x_s    = sext_acc(base_acc_s) + sext_acc(p_acc_s);
    mac_acc_s  = sat_acc(mac_x_s);
    mac_ovf_s  = ovf_acc(mac_x_s);
    // Saturation on earlier beats of an open sequence sticks to its result.
    mac_wsat_s = p_ovf_s || mac_ovf_s || (mac_active_q && mac_sat_q);

    res_acc_s  = {W_ACC{1'b0}};
    res_wsat_s = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        res_acc_s  = sat_acc(sum_x_s);
        res_wsat_s = ovf_acc(sum_x_s);
      end
      OP_MUL: begin
        res_acc_s  = p_acc_s;
        res_wsat_s = p_ovf_s;
      end
      OP_MAC: begin
        res_acc_s  = mac_acc_s;
        res_wsat_s = mac_wsat_s;
      end
      OP_RELU6: begin
        if (a_x_s[W_X-1]) begin
          res_acc_s = {W_ACC{1'b0}};
        end else if (a_x_s > RELU_MAX_X) begin
          res_acc_s = RELU_MAX_X[W_ACC-1:0];
        end else begin
          res_acc_s = a_x_s[W_ACC-1:0];
        end
        res_wsat_s = 1'b0;
      end
      default: begin
        res_acc_s  = {W_ACC{1'b0}};
        res_wsat_s = 1'b0;
      end
    endcase

    // The narrowing flag is raised whenever the value does not fit,
    // whether or not the caller asked for clamping.
    narrow_x_s = sext_acc(res_acc_s);
    res_nsat_s = ovf_data(narrow_x_s);
    if (s1_sat_q) begin
      res_r_s = sat_data(narrow_x_s);
    end else begin
      res_r_s = res_acc_s[W_DATA-1:0];
    end

    // Non-last MAC beats only update the accumulator and leave a bubble.
    emit_s     = s1_valid_q && ((s1_op_q != OP_MAC) || s1_last_q);
    mac_step_s = en_s && s1_valid_q && (s1_op_q == OP_MAC);
  end

  // Accumulator and MAC sequence tracking; other ops leave them untouched.
  always_comb begin
    acc_d        = acc_q;
    mac_active_d = mac_active_q;
    mac_sat_d    = mac_sat_q;
    if (mac_step_s) begin
      acc_d        = mac_acc_s;
      mac_active_d = !s1_last_q;
      mac_sat_d    = s1_last_q ? 1'b0 : mac_wsat_s;
    end else begin
      acc_d        = acc_q;
    end
  end

  // Output register: loads a result on enable, holds while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_acc_d   = out_acc_q;
    out_sat_d   = out_sat_q;
    if (en_s) begin
      out_valid_d = emit_s;
      if (emit_s) begin
        out_r_d   = res_r_s;
        out_acc_d = res_acc_s;
        out_sat_d = res_wsat_s || res_nsat_s;
      end else begin
        out_r_d   = out_r_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // All pipeline, accumulator and output flops; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= {W_DATA{1'b0}};
      s1_b_q       <= {W_DATA{1'b0}};
      s1_c_q       <= {W_DATA{1'b0}};
      s1_op_q      <= OP_ADD;
      s1_sat_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_prod_q    <= {W_P{1'b0}};
      acc_q        <= {W_ACC{1'b0}};
      mac_active_q <= 1'b0;
      mac_sat_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_r_q      <= {W_DATA{1'b0}};
      out_acc_q    <= {W_ACC{1'b0}};
      out_sat_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_c_q       <= s1_c_d;
      s1_op_q      <= s1_op_d;
      s1_sat_q     <= s1_sat_d;
      s1_last_q    <= s1_last_d;
      s1_prod_q    <= s1_prod_d;
      acc_q        <= acc_d;
      mac_active_q <= mac_active_d;
      mac_sat_q    <= mac_sat_d;
      out_valid_q  <= out_valid_d;
      out_r_q      <= out_r_d;
      out_acc_q    <= out_acc_d;
      out_sat_q    <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_processing_element_pipe.sv
// Scoreboard bench for processing_element_pipe (W_DATA=8, W_ACC=12, FRAC=4).
// The driver pushes hand-computed expectations when a beat is accepted; an
// independent monitor pops and compares whenever a result is transferred.
module tb_processing_element_pipe;

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_MUL   = 2'd1;
  localparam logic [1:0] OP_MAC   = 2'd2;
  localparam logic [1:0] OP_RELU6 = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b, in_c;
  logic        in_last;
  logic [1:0]  cfg_op;
  logic        cfg_sat;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_r;
  logic [11:0] out_acc;
  logic        out_sat;

  typedef struct packed {
    logic [7:0]  r;
    logic [11:0] acc;
    logic        sat;
    logic [31:0] acyc;
    logic        lat;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cyc = 32'd0;

  processing_element_pipe #(.W_DATA(8), .W_ACC(12), .FRAC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_last   (in_last),
    .cfg_op    (cfg_op),
    .cfg_sat   (cfg_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_acc   (out_acc),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every transferred result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: out_valid=1 with out_acc=0x%0h, expected no result", out_acc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_r",   32'(out_r),   32'(mon_e.r));
        chk("out_acc", 32'(out_acc), 32'(mon_e.acc));
        chk("out_sat", 32'(out_sat), 32'(mon_e.sat));
        if (mon_e.lat) chk("latency", cyc - mon_e.acyc, 32'd2);
      end
    end
  end

  // Drive one beat; returns on the cycle it is accepted (in_valid left high).
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic last, input logic sat,
                       input logic ev, input logic [7:0] er, input logic [11:0] ea,
                       input logic es, input logic lat);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1;
    cfg_op   = op;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_last  = last;
    cfg_sat  = sat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0, expected 1 within 100 cycles");
      in_valid = 1'b0;
    end else if (ev) begin
      e.r = er; e.acc = ea; e.sat = es; e.acyc = cyc; e.lat = lat;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((sb_q.size() == 0) && !out_valid) && n < 50);
    if (sb_q.size() != 0 || out_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d out_valid=%0b, expected 0 and 0", sb_q.size(), out_valid);
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = 8'h00; in_b = 8'h00; in_c = 8'h00; in_last = 1'b0;
    cfg_op = OP_ADD; cfg_sat = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_r",     32'(out_r),     32'd0);
    chk("rst_out_acc",   32'(out_acc),   32'd0);
    chk("rst_out_sat",   32'(out_sat),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;

    // MUL with latency check: 32*24=768, >>>4 = 48
    issue(OP_MUL, 8'h20, 8'h18, 8'h00, 1'b0, 1'b1, 1'b1, 8'h30, 12'h030, 1'b0, 1'b1);
    idle(); drain();

    // ADD 100+100 with and without clamping
    issue(OP_ADD, 8'd100, 8'd100, 8'h00, 1'b0, 1'b1, 1'b1, 8'd127, 12'd200, 1'b1, 1'b0);
    issue(OP_ADD, 8'd100, 8'd100, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC8,  12'd200, 1'b1, 1'b0);
    idle(); drain();

    // MAC: seed 16 plus four products of 16 -> 80, one result only
    for (int i = 1; i <= 4; i++) begin
      issue(OP_MAC, 8'h10, 8'h10, 8'h10, (i == 4), 1'b1, (i == 4), 8'h50, 12'h050, 1'b0, 1'b0);
    end
    idle(); drain();

    // MAC saturation: 1008*3 clamps to 2047; a following MUL is clean
    for (int i = 1; i <= 3; i++) begin
      issue(OP_MAC, 8'd127, 8'd127, 8'h00, (i == 3), 1'b1, (i == 3), 8'd127, 12'h7FF, 1'b1, 1'b0);
    end
    issue(OP_MUL, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 1'b1, 8'h10, 12'h010, 1'b0, 1'b0);
    idle(); drain();

    // RELU6 back-to-back: -5, 50, 120 -> 0, 50, 96 on consecutive cycles
    issue(OP_RELU6, 8'hFB,  8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0,  12'd0,  1'b0, 1'b1);
    issue(OP_RELU6, 8'd50,  8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'd50, 12'd50, 1'b0, 1'b1);
    issue(OP_RELU6, 8'd120, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'd96, 12'd96, 1'b0, 1'b1);
    idle(); drain();

    // Backpressure: two beats fill the pipe, the third waits, order kept
    out_ready = 1'b0;
    issue(OP_RELU6, 8'd7,  8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'd7, 12'd7, 1'b0, 1'b0);
    issue(OP_RELU6, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0, 12'd0, 1'b0, 1'b0);
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_in_ready",  32'(in_ready),  32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_hold_r",    32'(out_r),     32'd7);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join_none
    issue(OP_RELU6, 8'd90, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'd90, 12'd90, 1'b0, 1'b0);
    idle(); drain();

    // Reset in the middle of a MAC sequence with a result waiting
    out_ready = 1'b0;
    issue(OP_MAC, 8'h10, 8'h10, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0);
    issue(OP_MAC, 8'h10, 8'h10, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0);
    issue(OP_ADD, 8'd1,  8'd2,  8'h00, 1'b0, 1'b1, 1'b1, 8'd3,  12'd3,   1'b0, 1'b0);
    idle();
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_acc",   32'(out_acc),   32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    // Fresh sequence seeds from c: 32 + 16 = 48
    issue(OP_MAC, 8'h10, 8'h10, 8'h20, 1'b1, 1'b1, 1'b1, 8'h30, 12'h030, 1'b0, 1'b0);
    idle(); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/processing_element_pipe.md
Name: processing_element_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle vector-lane PE. It adds valid/ready handshakes, configurable data and accumulator widths, and a configurable fixed-point fraction.
- Performs ADD, fixed-point MUL, multi-beat MAC with an internal accumulator, and RELU6 on signed operands.
- Sits between the lane operand fetch and the lane writeback; one instance per vector lane.

Parameters:
- W_DATA, 8, operand and narrowed-result width (signed two's complement).
- W_ACC, 12, accumulator and wide-result width. Must satisfy W_ACC >= W_DATA.
- FRAC, 4, fractional bits; the product is arithmetically shifted right by FRAC. (6<<FRAC) must be <= 2^(W_DATA-1)-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_a  in  W_DATA  operand a
- in_b  in  W_DATA  operand b
- in_c  in  W_DATA  MAC seed, used on the first beat of a MAC sequence
- in_last  in  1  final beat of a MAC sequence (ignored for other ops)
- cfg_op  in  2  0=ADD, 1=MUL, 2=MAC, 3=RELU6; sampled with the beat
- cfg_sat  in  1  1: saturate out_r to W_DATA; 0: truncate to the low W_DATA bits
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_r  out  W_DATA  narrowed result
- out_acc  out  W_ACC  wide result before narrowing
- out_sat  out  1  saturation occurred anywhere in producing this result

Behaviour:
- Reset (asynchronous, rst=1): out_valid=0, out_r=0, out_acc=0, out_sat=0, all stage valids 0, acc=0, mac_active=0.
- While rst is asserted, in_ready=0.
- Pipeline enable: en = !out_valid || out_ready; in_ready = en && !rst. The whole pipeline stalls when en=0, with no bubble collapsing.
- A beat is accepted when in_valid && in_ready.
- Stage 1 registers the operands, op, sat, last, and the full 2*W_DATA signed product.
- Stage 2 computes the result and loads the output register.
- Latency: an accepted beat appears on out_valid exactly 2 en-cycles later.
- Throughput: 1 beat per cycle when out_ready is held high.
- Results hold stable while out_valid && !out_ready.
- ADD: sum = sext(a) + sext(b), computed in W_ACC+1 bits. out_acc = sum saturated to W_ACC.
- MUL: p = product >>> FRAC. out_acc = p saturated to W_ACC.
- MAC, per beat:
  - base = mac_active ? acc : sext(c).
  - s = base + sat_W_ACC(p), saturated to W_ACC; acc <= s.
  - Non-last beat: mac_active <= 1 and no output is produced (bubble).
  - Last beat: emit out_acc = s, then mac_active <= 0.
  - A single-beat MAC (first beat with last=1) yields sext(c) + p.
- RELU6: out_acc = clamp(sext(a), 0, 6<<FRAC).
- Narrowing:
  - out_r = cfg_sat ? sat_W_DATA(out_acc) : out_acc[W_DATA-1:0].
  - out_sat = OR of any W_ACC saturation (including those on earlier beats of the same MAC sequence) and any W_DATA narrowing saturation.
- Non-MAC beats interleaved inside an open MAC sequence pass through normally and leave acc and mac_active untouched.
- Saturation bounds are symmetric to type: max = 2^(W-1)-1, min = -2^(W-1).
- A reset mid-sequence discards all in-flight beats and the partial accumulation. The next MAC beat seeds from c.
- out_valid does not depend combinationally on in_valid. in_ready depends only on state, out_ready and rst.

Test Plan (W_DATA=8, W_ACC=12, FRAC=4):
- MUL: a=0x20, b=0x18, sat=1 -> out_r=0x30, out_acc=0x030, out_sat=0, out_valid exactly 2 cycles after accept.
- ADD: a=100, b=100 with sat=1 -> out_r=127, out_acc=200, out_sat=1. Same operands with sat=0 -> out_r=0xC8, out_sat=1.
- MAC: 4 beats a=b=0x10, c=0x10, last on beat 4 -> a single output, out_acc=0x050, out_r=0x50, no outputs for beats 1-3.
- MAC saturation: 3 beats a=b=127, c=0 -> each p=1008, out_acc=2047, out_sat=1. A following MUL beat a=b=0x10 -> out_acc=0x010, out_sat=0.
- RELU6: a=-5, 50, 120 back-to-back -> out_r=0, 50, 96 on consecutive cycles. Then hold out_ready=0 and push 3 more beats -> in_ready falls after 2 are in flight, no loss, original order preserved on release.
- Reset mid-MAC: assert rst after 2 MAC beats (c=0x10) -> out_valid=0 immediately. A post-reset single MAC beat a=b=0x10, c=0x20, last=1 -> out_acc=0x030.
